// File: rtl/beat_sequencer.sv
// Pattern playback: walks a STEPS x CODE_W beat register at a programmable
// per-step period, emitting step index, start strobe, note code and gate.
module beat_sequencer #(
  parameter int STEPS      = 16,
  parameter int CODE_W     = 3,
  parameter int MIN_PERIOD = 2,
  parameter int PW         = 24
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [STEPS*CODE_W-1:0]   beats,
  input  logic                      run,
  input  logic [PW-1:0]             step_period,
  output logic [$clog2(STEPS)-1:0]  step,
  output logic                      step_strobe,
  output logic [CODE_W-1:0]         note_code,
  output logic                      gate,
  output logic                      playing
);
  localparam int IW = $clog2(STEPS);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     cnt, cnt_nxt, per, per_nxt;
  logic [PW-1:0]     cnt_inc, per_in;
  logic [IW-1:0]     step_nxt, start_idx;
  logic              strobe_nxt, gate_nxt, start;
  logic [CODE_W-1:0] note_nxt, start_code;

  assign cnt_inc    = cnt + 1'b1;
  assign per_in     = (step_period < PW'(MIN_PERIOD)) ? PW'(MIN_PERIOD) : step_period;
  assign start_code = beats[start_idx*CODE_W +: CODE_W];

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    per_nxt    = per;
    step_nxt   = step;
    note_nxt   = note_code;
    gate_nxt   = gate;
    strobe_nxt = 1'b0;
    start      = 1'b0;
    start_idx  = '0;
    case (state)
      IDLE: begin
        if (run) start = 1'b1;
      end
      PLAY: begin
        if (!run) begin
          // stop wins over a coincident step boundary
          state_nxt = IDLE;
          cnt_nxt   = '0;
          step_nxt  = '0;
          note_nxt  = '0;
          gate_nxt  = 1'b0;
        end else if (cnt_inc == per) begin
          start     = 1'b1;
          start_idx = step + 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == (per >> 1)) gate_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (start) begin
      state_nxt  = PLAY;
      cnt_nxt    = '0;
      per_nxt    = per_in;
      step_nxt   = start_idx;
      note_nxt   = start_code;
      gate_nxt   = (start_code != '0);
      strobe_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      per         <= PW'(MIN_PERIOD);
      step        <= '0;
      step_strobe <= 1'b0;
      note_code   <= '0;
      gate        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      per         <= per_nxt;
      step        <= step_nxt;
      step_strobe <= strobe_nxt;
      note_code   <= note_nxt;
      gate        <= gate_nxt;
    end
  end

  assign playing = (state == PLAY);
endmodule

// File: tb/tb_beat_sequencer.sv
// Self-checking bench for beat_sequencer: time-based reference model plus
// directed literal checks and a randomized playback phase.
module tb_beat_sequencer;
  logic        clk = 0;
  logic        rst_n = 0;
  logic [47:0] beats = '0;
  logic        run = 0;
  logic [23:0] step_period = '0;
  logic [3:0]  step;
  logic        step_strobe;
  logic [2:0]  note_code;
  logic        gate;
  logic        playing;

  int n_cmp = 0;
  int n_bad = 0;

  beat_sequencer dut (
    .clk(clk), .rst_n(rst_n), .beats(beats), .run(run),
    .step_period(step_period), .step(step), .step_strobe(step_strobe),
    .note_code(note_code), .gate(gate), .playing(playing)
  );

  always #5 clk = ~clk;

  // Reference model: step index, time elapsed since the step started,
  // and the note/period captured at that start.
  bit   m_play;
  int   m_step, m_el, m_P;
  logic [2:0] m_note;

  task automatic m_start(input int k);
    m_play = 1;
    m_step = k % 16;
    m_note = beats[3*m_step +: 3];
    m_P    = (step_period < 2) ? 2 : int'(step_period);
    m_el   = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_play = 0; m_step = 0; m_note = 0; m_P = 2; m_el = 0;
    end else if (!m_play) begin
      if (run) m_start(0);
    end else if (!run) begin
      m_play = 0; m_step = 0; m_note = 0; m_el = 0;
    end else if (m_el + 1 >= m_P) begin
      m_start(m_step + 1);
    end else begin
      m_el++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("playing", playing, m_play);
      chk("step", step, m_play ? m_step : 0);
      chk("strobe", step_strobe, (m_play && m_el == 0) ? 1 : 0);
      chk("note", note_code, m_play ? m_note : 0);
      chk("gate", gate, (m_play && m_note != 0 && m_el < m_P / 2) ? 1 : 0);
    end
  end

  task automatic waitn(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic stop1();
    run = 0;
    waitn(1);
  endtask

  initial begin
    waitn(3);
    chk("rst_step", step, 0);
    chk("rst_play", playing, 0);
    rst_n = 1;
    waitn(2);
    chk("idle_hold", playing, 0);

    // basic play, all rests, P=4
    beats = '0; step_period = 4; run = 1;
    waitn(1);
    chk("bp_s0", step, 0); chk("bp_str0", step_strobe, 1);
    waitn(4);
    chk("bp_s1", step, 1); chk("bp_gate", gate, 0);
    waitn(60);
    chk("bp_wrap", step, 0); chk("bp_wrap_str", step_strobe, 1);
    stop1();

    // note codes 5,0,7 with P=6
    beats = 48'd5 | (48'd0 << 3) | (48'd7 << 6); step_period = 6; run = 1;
    waitn(1);
    chk("nc_note0", note_code, 5); chk("nc_gate0", gate, 1);
    waitn(2); chk("nc_gate0_hi", gate, 1);
    waitn(1); chk("nc_gate0_lo", gate, 0);
    waitn(3); chk("nc_s1", step, 1); chk("nc_note1", note_code, 0); chk("nc_gate1", gate, 0);
    waitn(6); chk("nc_s2", step, 2); chk("nc_note2", note_code, 7); chk("nc_gate2", gate, 1);
    stop1();

    // clamp: step_period=0 behaves as 2
    beats = {16{3'd3}}; step_period = 0; run = 1;
    waitn(1); chk("cl_gate", gate, 1);
    waitn(1); chk("cl_gate_lo", gate, 0); chk("cl_s0", step, 0);
    waitn(1); chk("cl_s1", step, 1); chk("cl_str", step_strobe, 1);
    stop1();

    // odd period 5: gate 2 cycles
    step_period = 5; run = 1;
    waitn(2); chk("p5_gate_hi", gate, 1);
    waitn(1); chk("p5_gate_lo", gate, 0);
    waitn(3); chk("p5_s1", step, 1);
    stop1();

    // mid-step period/pattern change in step 3, then stop in step 9
    beats = 48'd6 << 9; step_period = 8; run = 1;
    waitn(25); chk("mc_s3", step, 3); chk("mc_note3", note_code, 6);
    waitn(2);
    step_period = 3; beats[11:9] = 3'd1;
    waitn(5); chk("mc_s3_hold", step, 3); chk("mc_note_hold", note_code, 6);
    waitn(1); chk("mc_s4", step, 4);
    waitn(3); chk("mc_s5", step, 5);
    waitn(13); chk("mc_s9", step, 9);
    run = 0;
    waitn(1); chk("sp_play", playing, 0); chk("sp_step", step, 0); chk("sp_gate", gate, 0);
    run = 1;
    waitn(1); chk("rs_s0", step, 0); chk("rs_str", step_strobe, 1); chk("rs_play", playing, 1);
    stop1();

    // async reset mid-gate in step 6
    beats = 48'd2 << 18; step_period = 8; run = 1;
    waitn(49); chk("ar_s6", step, 6); chk("ar_gate", gate, 1);
    waitn(1);
    #1 rst_n = 0;
    #1;
    chk("ar_step", step, 0); chk("ar_gate0", gate, 0); chk("ar_play", playing, 0);
    chk("ar_note", note_code, 0); chk("ar_str", step_strobe, 0);
    waitn(2);
    rst_n = 1;
    waitn(1); chk("ar_rs_s0", step, 0); chk("ar_rs_str", step_strobe, 1);

    // randomized playback
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) run = ~run;
      else if (!run && $urandom_range(0, 3) == 0) run = 1;
      if ($urandom_range(0, 15) == 0) step_period = 24'($urandom_range(0, 9));
      if ($urandom_range(0, 7) == 0) beats = {$urandom(), $urandom()};
    end
    run = 0;
    waitn(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/beat_sequencer.md
# beat_sequencer

Playback stage that consumes the 48-bit pattern register (16 steps × 3-bit codes) produced by the pattern model and steps through it at a programmable rate. For each step it emits the step index, a one-cycle step strobe, the 3-bit note code, and a gate. It sits downstream of the pattern model and feeds the tone/output stage and the step-indicator LEDs.

## Interface
- STEPS, 16, number of steps in the pattern; index width is 4.
- CODE_W, 3, bits per step code; `beats` width is STEPS*CODE_W = 48.
- MIN_PERIOD, 2, minimum cycles per step; smaller `step_period` values are clamped up to this.

- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- beats  in  48  pattern; step k code = beats[3k+2:3k]; code 0 = rest.
- run  in  1  level; 1 = play, 0 = stop.
- step_period  in  24  cycles per step; latched only at each step start.
- step  out  4  current step index.
- step_strobe  out  1  one-cycle pulse on the first cycle of each step.
- note_code  out  3  code of the current step, captured at step start.
- gate  out  1  high for the first half of a non-rest step.
- playing  out  1  high while in PLAY.

## Operation
- Two states: IDLE and PLAY. Reset enters IDLE.
- Reset values: step=0, step_strobe=0, note_code=0, gate=0, playing=0. Internal cycle counter=0 and latched period=MIN_PERIOD.
- IDLE: all outputs hold their reset values. If run=1 at a clock edge, enter PLAY at that edge and start step 0.
- Step start, at edge E for step k:
  - step=k, step_strobe=1, playing=1.
  - note_code=beats[3k+2:3k], sampled at E.
  - P = max(step_period, MIN_PERIOD), sampled at E and latched.
  - counter=0.
  - gate=(note_code≠0).
- PLAY, non-start cycles:
  - counter increments and step_strobe=0.
  - gate clears on the edge where counter becomes P>>1 (floor).
  - On the edge where counter would reach P, the next step starts, with k+1 mod 16 (15 wraps to 0).
- Pattern change mid-step: `beats` changes do not alter note_code or gate until the next step start.
- Period change mid-step: no effect until the next step start.
- Stop: if run=0 at an edge in PLAY, enter IDLE at that edge. All outputs return to reset values and step returns to 0. A stop at a step boundary takes priority over starting the next step.
- Restart after stop always begins at step 0.
- Reset asserted mid-step: all outputs clear immediately (asynchronously). After release, the block stays in IDLE until run is sampled high.
- Arithmetic:
  - counter is 24-bit unsigned.
  - P>>1 is a truncating shift.
  - The step index wraps naturally in 4 bits.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Start latency: run sampled high at edge N gives step=0 with step_strobe=1 valid after edge N.
- Step starts occur at edges N, N+P0, N+P0+P1, … where Pi is the period latched at step i.
- step_strobe is exactly 1 cycle wide. Two strobes are always at least MIN_PERIOD cycles apart.
- Gate is high for exactly floor(P/2) cycles from the step-start edge. P=2 gives 1 cycle; P=5 gives 2 cycles.
- Stop latency: run sampled low at edge M gives playing=0, gate=0 and step=0 valid after edge M.

## Test plan
- Basic play: beats=48'h0, step_period=4, run=1 → step advances 0,1,2,… every 4 cycles; strobe on each change; gate stays 0; 15 wraps to 0 after 64 cycles.
- Note codes: beats[2:0]=3'd5, beats[5:3]=3'd0, beats[8:6]=3'd7, P=6 →
  - step 0: note_code=5, gate high 3 cycles;
  - step 1: note_code=0, gate low;
  - step 2: note_code=7, gate high 3 cycles.
- Clamp and odd period: step_period=0 → step advances every 2 cycles with gate 1 cycle. step_period=5 → advances every 5 cycles with gate 2 cycles.
- Mid-step changes: while in step 3 with P=8, change step_period to 3 and beats[11:9] → current step still lasts 8 cycles and keeps the old note_code; step 4 lasts 3 cycles.
- Stop/restart: run=0 during step 9 → next edge playing=0, gate=0, step=0. run=1 again → step 0 with strobe one edge later.
- Async reset: assert rst_n=0 mid-gate at step 6 → all outputs 0 immediately, without a clock edge. Release with run=1 → play starts at step 0 on the first edge after release.
